// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status enable bits
// and the default handler vector.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [1:0] {
    EXC_INT    = 2'b00,
    EXC_SYS    = 2'b01,
    EXC_UNIMPL = 2'b10,
    EXC_OVR    = 2'b11
  } exc_code_e;

  localparam int ST_IE_INT    = 0;
  localparam int ST_IE_SYS    = 1;
  localparam int ST_IE_UNIMPL = 2;
  localparam int ST_IE_OVR    = 3;

  localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0008;

  // Cause as seen by mfc0: only ExcCode in [3:2] is implemented.
  function automatic logic [31:0] cause_word(input exc_code_e code);
    return {28'h000_0000, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_sync.sv
// Multi-flop synchronizer for the asynchronous interrupt request level.
module cp0_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain; the oldest sample leaves at the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller: Status/Cause/EPC, trap prioritisation,
// PC redirect, write-back kill and interrupt acknowledge.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR      = VECTOR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_next_i,
  input  logic        v_i,
  input  logic        ov_en_i,
  input  logic        sys_i,
  input  logic        unimpl_i,
  input  logic        eret_i,
  input  logic        mtc0_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wdata_i,
  input  logic        intr_i,
  output logic [31:0] rdata_o,
  output logic        exc_take_o,
  output logic        wb_kill_o,
  output logic [31:0] pc_sel_out_o,
  output logic        inta_o
);

  logic [31:0] status_q, status_d;
  exc_code_e   cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        inta_q, inta_d;

  logic        irq_s;
  logic        ovr_req_s, unimpl_req_s, sys_req_s, int_req_s;
  logic        exc_take_s;
  exc_code_e   code_s;

  cp0_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(intr_i),
    .sync_o (irq_s)
  );

  // Gate each source by its enable and pick the highest-priority winner.
  always_comb begin
    ovr_req_s    = v_i & ov_en_i & status_q[ST_IE_OVR];
    unimpl_req_s = unimpl_i & status_q[ST_IE_UNIMPL];
    sys_req_s    = sys_i & status_q[ST_IE_SYS];
    // inta blocks a re-take while the device is still releasing intr.
    int_req_s    = irq_s & status_q[ST_IE_INT] & ~eret_i & ~inta_q;
    exc_take_s   = ovr_req_s | unimpl_req_s | sys_req_s | int_req_s;
    if (ovr_req_s) begin
      code_s = EXC_OVR;
    end else if (unimpl_req_s) begin
      code_s = EXC_UNIMPL;
    end else if (sys_req_s) begin
      code_s = EXC_SYS;
    end else begin
      code_s = EXC_INT;
    end
  end

  // Next-state for CP0 registers: a taken exception overrides eret and mtc0.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    inta_d   = 1'b0;
    if (exc_take_s) begin
      epc_d    = (code_s == EXC_INT) ? pc_next_i : pc_i;
      cause_d  = code_s;
      status_d = status_q << 3'd4;
      inta_d   = (code_s == EXC_INT);
    end else begin
      if (eret_i) begin
        status_d = status_q >> 3'd4;
      end else begin
        status_d = status_q;
      end
      if (mtc0_i) begin
        case (rd_i)
          CP0_STATUS: status_d = wdata_i;
          CP0_CAUSE:  cause_d  = exc_code_e'(wdata_i[3:2]);
          CP0_EPC:    epc_d    = wdata_i;
          default:    cause_d  = cause_q;
        endcase
      end else begin
        cause_d = cause_q;
      end
    end
  end

  // CP0 state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= 32'h0000_0000;
      cause_q  <= EXC_INT;
      epc_q    <= 32'h0000_0000;
      inta_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      inta_q   <= inta_d;
    end
  end

  // mfc0 read mux; shows pre-edge values only.
  always_comb begin
    case (rd_i)
      CP0_STATUS: rdata_o = status_q;
      CP0_CAUSE:  rdata_o = cause_word(cause_q);
      CP0_EPC:    rdata_o = epc_q;
      default:    rdata_o = 32'h0000_0000;
    endcase
  end

  // PC source selection and write-back kill.
  always_comb begin
    if (exc_take_s) begin
      pc_sel_out_o = VECTOR;
    end else if (eret_i) begin
      pc_sel_out_o = epc_q;
    end else begin
      pc_sel_out_o = pc_next_i;
    end
    wb_kill_o = ovr_req_s | unimpl_req_s;
  end

  assign exc_take_o = exc_take_s;
  assign inta_o     = inta_q;

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt controller for the single-cycle CPU.
- Sits directly downstream of the ALU. Consumes its overflow flag V together with decoder trap flags and the external interrupt line.
- Owns the Status, Cause and EPC registers. Produces the PC redirect, the write-back kill and the interrupt acknowledge.
- Serves mfc0/mtc0/eret.

Parameters:
- VECTOR, 32'h00000008, exception handler entry address.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous intr input (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  PC of the instruction executing this cycle.
- pc_next  in  32  sequential/branch next PC computed by the datapath.
- v  in  1  ALU overflow flag for this cycle.
- ov_en  in  1  instruction is a trapping add/sub/addi.
- sys  in  1  syscall decoded.
- unimpl  in  1  unimplemented opcode decoded.
- eret  in  1  eret decoded.
- mtc0  in  1  write CP0 register rd with wdata.
- rd  in  5  CP0 register select: 12 Status, 13 Cause, 14 EPC.
- wdata  in  32  mtc0 data (rt value).
- intr  in  1  external interrupt request, level, asynchronous.
- rdata  out  32  mfc0 read data, combinational on rd.
- exc_take  out  1  redirect to VECTOR this cycle (combinational).
- wb_kill  out  1  suppress register-file write of the current instruction.
- pc_sel_out  out  32  PC to load: VECTOR, EPC, or pc_next.
- inta  out  1  one-cycle interrupt acknowledge pulse, registered.

Behaviour:
- Registers:
  - Status[31:0]: bits [3:0] are enables for intr, sys, unimpl, ovr. Bits [11:4] hold two saved copies.
  - Cause[3:2] = ExcCode: 00 intr, 01 sys, 10 unimpl, 11 ovr. Other bits read 0.
  - EPC[31:0].
- Reset (rst=1 at edge): Status=0, Cause=0, EPC=0, sync chain=0, inta=0.
  - All traps are masked after reset.
  - rst has priority over every other input in the same cycle.
- Interrupt sync: intr passes SYNC_STAGES flops; the last flop output is irq_s.
- Candidate events, priority high to low:
  1. ovr_req = v & ov_en & Status[3]
  2. unimpl_req = unimpl & Status[2]
  3. sys_req = sys & Status[1]
  4. int_req = irq_s & Status[0] & ~eret & ~inta
- exc_take = OR of the four requests. The highest-priority request selects the ExcCode.
- wb_kill = ovr_req | unimpl_req. The overflowing result is never written. sys writes nothing anyway.
- On exc_take, at the clock edge:
  - EPC <= pc for synchronous exceptions (re-execute/inspect the faulting instruction).
  - EPC <= pc_next for an interrupt (the current instruction completes normally).
  - Cause[3:2] <= code.
  - Status <= Status << 4: masks all sources and nests one level.
- inta <= int_req was the winning event. It is high exactly one cycle after the interrupt is taken and blocks re-taking while the external device drops intr.
- eret without exc_take: Status <= Status >> 4 and pc_sel_out = EPC.
- mtc0 without exc_take: the register selected by rd is written at the edge. Writes to other rd values are ignored.
- An exception in the same cycle as mtc0 wins; the mtc0 write is dropped.
- pc_sel_out = VECTOR if exc_take, else EPC if eret, else pc_next.
- rdata: Status/Cause/EPC for rd 12/13/14, else 0. Reads show the pre-edge values; there is no bypass of a same-cycle mtc0.
- Masked events are silently ignored. Nothing is latched except the intr level, which stays pending while intr is held.
- ov_en=0 with v=1 (addu/subu) never traps.

Decomposition:
- Shared package cp0_pkg: CP0 register numbers (12, 13, 14), ExcCode constants, Status bit indices, default VECTOR.
- One sub-module: cp0_sync, a parameterised SYNC_STAGES flop chain for intr with synchronous active-high reset.

Test Plan:
- Reset, then intr=1 and sys=1 with Status=0 -> exc_take=0, pc_sel_out=pc_next, rdata(rd=12)=0.
- mtc0 rd=12 wdata=0xF. Then add with X=0x7FFFFFFF, Y=1, v=1, ov_en=1, pc=0x40 -> exc_take=1, wb_kill=1, pc_sel_out=0x8. After the edge: EPC=0x40, Cause=0xC, Status=0xF0.
- Status=0xF, simultaneous v&ov_en, unimpl, sys and irq_s -> Cause code 11 (ovr). A following eret restores Status=0xF and pc_sel_out=EPC.
- Status=0x1, assert intr with pc_next=0x104 -> exc_take exactly SYNC_STAGES cycles later, EPC=0x104, Cause=0x0, inta high one cycle, no second take while intr is held (Status masked).
- mtc0 rd=14 wdata=0x200 followed by eret -> pc_sel_out=0x200. mtc0 coincident with sys under Status=0x2 -> EPC=pc, the write is dropped.
- rst asserted mid-handler (Status=0xF0) -> all registers 0 next cycle, inta=0.
